// File: rtl/interval_timer_counter.sv
// Interval timer: prescaled start/stop/clear counter with binary and 3-digit BCD outputs.
// Optional lap capture is enabled with `define COUNTER_LAP_EN.
module interval_timer_counter #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LIMIT     = 99,
  parameter int unsigned AUTO_WRAP = 0
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             clear,
  input  logic             start_stop,
  output logic [WIDTH-1:0] counter,
  output logic [11:0]      bcd,
  output logic             running,
  output logic             tick,
  output logic             done,
  output logic             wrap
`ifdef COUNTER_LAP_EN
  ,
  input  logic             lap,
  output logic [WIDTH-1:0] lap_value,
  output logic             lap_valid
`endif
);

  localparam int unsigned      DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned      PW        = $clog2(DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] LIMIT_V   = WIDTH'(LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [11:0]      bcd_q, bcd_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             ss_meta_q, ss_sync_q, ss_prev_q;
  logic             ss_edge;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] == 4'd9) begin
      r[3:0] = '0;
      if (r[7:4] == 4'd9) begin
        r[7:4] = '0;
        r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
      end else begin
        r[7:4] = r[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

  assign ss_edge = ss_sync_q & ~ss_prev_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE, S_PAUSE: if (ss_edge) state_d = S_RUN;
      S_RUN: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (cnt_q != LIMIT_V) begin
            cnt_d = cnt_q + WIDTH'(1);
            bcd_d = bcd_inc(bcd_q);
          end else if (AUTO_WRAP != 0) begin
            cnt_d  = '0;
            bcd_d  = '0;
            wrap_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // A same-cycle toggle pauses after the tick; reaching DONE takes precedence.
        if (ss_edge && state_d == S_RUN) state_d = S_PAUSE;
      end
      S_DONE: begin
        if (ss_edge) begin
          state_d = S_RUN;
          cnt_d   = '0;
          bcd_d   = '0;
          presc_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      cnt_d   = '0;
      bcd_d   = '0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      ss_meta_q <= 1'b0;
      ss_sync_q <= 1'b0;
      ss_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      ss_meta_q <= start_stop;
      ss_sync_q <= ss_meta_q;
      ss_prev_q <= ss_sync_q;
    end
  end

  assign counter = cnt_q;
  assign bcd     = bcd_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

`ifdef COUNTER_LAP_EN
  logic             lap_meta_q, lap_sync_q, lap_prev_q;
  logic [WIDTH-1:0] lap_value_q, lap_value_d;
  logic             lap_valid_q, lap_valid_d;

  // Capture the post-tick count so a same-cycle tick is included in the lap.
  always_comb begin
    lap_value_d = lap_value_q;
    lap_valid_d = lap_valid_q;
    if (lap_sync_q && !lap_prev_q) begin
      lap_value_d = cnt_d;
      lap_valid_d = 1'b1;
    end
    if (clear) begin
      lap_value_d = '0;
      lap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      lap_meta_q  <= 1'b0;
      lap_sync_q  <= 1'b0;
      lap_prev_q  <= 1'b0;
      lap_value_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_meta_q  <= lap;
      lap_sync_q  <= lap_meta_q;
      lap_prev_q  <= lap_sync_q;
      lap_value_q <= lap_value_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_value = lap_value_q;
  assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_interval_timer_counter.sv
// Scoreboard bench for interval_timer_counter: three instances (stop-at-limit, auto-wrap, LIMIT=120).
module tb_interval_timer_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  clr = '0;
  logic [2:0]  ss = '0;
  logic [15:0] cnt [3];
  logic [11:0] bcd [3];
  logic [2:0]  run, tck, dn, wr;
`ifdef COUNTER_LAP_EN
  logic [2:0]  lap = '0;
  logic [15:0] lapv [3];
  logic [2:0]  lapok;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [15:0] cnt;
    logic [11:0] bcd;
    logic        wrap;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  interval_timer_counter #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(16), .LIMIT(5), .AUTO_WRAP(0)) u_stop (
    .CLK100MHZ(clk), .reset(rst_n), .clear(clr[0]), .start_stop(ss[0]),
    .counter(cnt[0]), .bcd(bcd[0]), .running(run[0]), .tick(tck[0]), .done(dn[0]), .wrap(wr[0])
`ifdef COUNTER_LAP_EN
    , .lap(lap[0]), .lap_value(lapv[0]), .lap_valid(lapok[0])
`endif
  );

  interval_timer_counter #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(16), .LIMIT(5), .AUTO_WRAP(1)) u_wrap (
    .CLK100MHZ(clk), .reset(rst_n), .clear(clr[1]), .start_stop(ss[1]),
    .counter(cnt[1]), .bcd(bcd[1]), .running(run[1]), .tick(tck[1]), .done(dn[1]), .wrap(wr[1])
`ifdef COUNTER_LAP_EN
    , .lap(lap[1]), .lap_value(lapv[1]), .lap_valid(lapok[1])
`endif
  );

  interval_timer_counter #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(16), .LIMIT(120), .AUTO_WRAP(0)) u_big (
    .CLK100MHZ(clk), .reset(rst_n), .clear(clr[2]), .start_stop(ss[2]),
    .counter(cnt[2]), .bcd(bcd[2]), .running(run[2]), .tick(tck[2]), .done(dn[2]), .wrap(wr[2])
`ifdef COUNTER_LAP_EN
    , .lap(lap[2]), .lap_value(lapv[2]), .lap_valid(lapok[2])
`endif
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Decimal digits come from integer division, independent of any carry chain.
  function automatic void push(int id, int unsigned c, logic w);
    exp_t e;
    e.id   = id;
    e.cnt  = 16'(c);
    e.bcd  = {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    e.wrap = w;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && tck[i]) begin
        chk("tick_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("tick_dut_id", i, e.id);
          chk("tick_counter", cnt[i], e.cnt);
          chk("tick_bcd", bcd[i], e.bcd);
          chk("tick_wrap", wr[i], e.wrap);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss(int id);
    ss[id] = 1'b1;
    step(1);
    ss[id] = 1'b0;
  endtask

  task automatic start(int id);
    pulse_ss(id);
    step(1);
    chk("pre_run", run[id], 0);
    step(1);
    chk("run_latency", run[id], 1);
  endtask

  task automatic wait_tick(int id, int gap);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tck[id] && n < 200);
    chk("tick_gap", n, gap);
  endtask

  task automatic do_clear(int id);
    clr[id] = 1'b1;
    step(1);
    clr[id] = 1'b0;
    chk("clear_run", run[id], 0);
    chk("clear_cnt", cnt[id], 0);
  endtask

  initial begin
    #23;
    for (int i = 0; i < 3; i++) begin
      chk("rst_cnt", cnt[i], 0);
      chk("rst_bcd", bcd[i], 0);
      chk("rst_run", run[i], 0);
      chk("rst_tick", tck[i], 0);
      chk("rst_done", dn[i], 0);
      chk("rst_wrap", wr[i], 0);
    end
    step(1);
    rst_n = 1'b1;
    step(2);

    // Stop-at-limit instance: count, pause/resume, done, restart.
    for (int c = 1; c <= 3; c++) push(0, c, 1'b0);
    start(0);
    wait_tick(0, 10);
    wait_tick(0, 10);
    step(1);
    pulse_ss(0);
    step(2);
    chk("paused_run", run[0], 0);
    step(50);
    chk("paused_cnt", cnt[0], 2);
    start(0);
    wait_tick(0, 6);
    push(0, 4, 1'b0);
    push(0, 5, 1'b0);
    push(0, 5, 1'b0);
    wait_tick(0, 10);
    wait_tick(0, 10);
    wait_tick(0, 10);
    chk("done_flag", dn[0], 1);
    chk("done_run", run[0], 0);
    step(20);
    chk("done_hold_cnt", cnt[0], 5);
    start(0);
    chk("restart_cnt", cnt[0], 0);
    chk("restart_bcd", bcd[0], 0);
    chk("restart_done", dn[0], 0);
    do_clear(0);

    // Auto-wrap instance.
    for (int c = 1; c <= 5; c++) push(1, c, 1'b0);
    push(1, 0, 1'b1);
    start(1);
    for (int k = 0; k < 6; k++) wait_tick(1, 10);
    chk("wrap_pulse", wr[1], 1);
    chk("wrap_run", run[1], 1);
    chk("wrap_done", dn[1], 0);
    step(1);
    chk("wrap_one_cycle", wr[1], 0);
    do_clear(1);

    // LIMIT=120 instance: BCD carries, then clear against a same-cycle toggle.
    for (int c = 1; c <= 110; c++) push(2, c, 1'b0);
    start(2);
    for (int k = 0; k < 110; k++) wait_tick(2, 10);
    chk("bcd_110", bcd[2], 32'h110);
    ss[2] = 1'b1;
    step(2);
    do_clear(2);
    chk("clear_bcd", bcd[2], 0);
    step(5);
    chk("clear_stays_idle", run[2], 0);
    ss[2] = 1'b0;

    // Lap capture and asynchronous reset mid-run.
    for (int c = 1; c <= 3; c++) push(0, c, 1'b0);
    start(0);
    for (int k = 0; k < 3; k++) wait_tick(0, 10);
`ifdef COUNTER_LAP_EN
    lap[0] = 1'b1;
    step(3);
    lap[0] = 1'b0;
    chk("lap_value", lapv[0], 3);
    chk("lap_valid", lapok[0], 1);
`endif
    step(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt[0], 0);
    chk("async_rst_bcd", bcd[0], 0);
    chk("async_rst_run", run[0], 0);
    chk("async_rst_tick", tck[0], 0);
`ifdef COUNTER_LAP_EN
    chk("async_rst_lapv", lapv[0], 0);
    chk("async_rst_lapok", lapok[0], 0);
`endif
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
